// File: rtl/fusion_seq_pkg.sv
// Shared types and helpers for the fusion_unit job sequencer.
package fusion_seq_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, DONE} state_t;

  localparam logic [2:0] W1 = 3'd1;
  localparam logic [2:0] W2 = 3'd2;
  localparam logic [2:0] W4 = 3'd4;

  function automatic logic width_ok(input logic [2:0] w);
    return (w == W1) || (w == W2) || (w == W4);
  endfunction

  // Accumulator widths up to 32 bits are covered by this extension.
  function automatic logic [31:0] ext_psum(input logic [7:0] psum, input logic sgn);
    return sgn ? {{24{psum[7]}}, psum} : {24'd0, psum};
  endfunction

endpackage

// File: rtl/fu_lat_tracker.sv
// Delays fu_valid by the fusion_unit latency so the matching psum can be picked up.
module fu_lat_tracker #(
  parameter int unsigned FU_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic out_valid,
  output logic empty
);

  localparam logic [FU_LAT-1:0] UP_MASK = {FU_LAT{1'b1}} >> 1;

  logic [FU_LAT-1:0] pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe <= '0;
    else        pipe <= FU_LAT'({pipe, in_valid});
  end

  assign out_valid = pipe[FU_LAT-1];
  // Nothing in flight except possibly the psum landing this cycle.
  assign empty = !in_valid && !(|(pipe & UP_MASK));

endmodule

// File: rtl/fusion_seq_ctrl.sv
// Job sequencer: streams operand pairs into fusion_unit and accumulates its psums.
module fusion_seq_ctrl
  import fusion_seq_pkg::*;
#(
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned FU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [LEN_W-1:0] job_len,
  input  logic [2:0]       job_in_width,
  input  logic [2:0]       job_weight_width,
  input  logic             job_s_in,
  input  logic             job_s_weight,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [3:0]       din_in,
  input  logic [3:0]       din_weight,
  output logic [3:0]       fu_in,
  output logic [3:0]       fu_weight,
  output logic [2:0]       fu_in_width,
  output logic [2:0]       fu_weight_width,
  output logic             fu_s_in,
  output logic             fu_s_weight,
  output logic             fu_valid,
  input  logic [7:0]       fu_psum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             res_err
);

  state_t           state;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic             trk_valid;
  logic             trk_empty;

  fu_lat_tracker #(.FU_LAT(FU_LAT)) u_trk (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (fu_valid),
    .out_valid (trk_valid),
    .empty     (trk_empty)
  );

  always_comb begin
    acc_next = acc;
    if (trk_valid) acc_next = acc + ACC_W'(ext_psum(fu_psum, fu_s_in || fu_s_weight));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      len             <= '0;
      cnt             <= '0;
      acc             <= '0;
      job_ready       <= 1'b0;
      din_ready       <= 1'b0;
      fu_in           <= '0;
      fu_weight       <= '0;
      fu_in_width     <= '0;
      fu_weight_width <= '0;
      fu_s_in         <= 1'b0;
      fu_s_weight     <= 1'b0;
      fu_valid        <= 1'b0;
      res_valid       <= 1'b0;
      res_data        <= '0;
      res_err         <= 1'b0;
    end else begin
      fu_valid <= 1'b0;
      acc      <= acc_next;
      case (state)
        IDLE: begin
          job_ready <= 1'b1;
          if (job_valid && job_ready) begin
            job_ready       <= 1'b0;
            len             <= job_len;
            fu_in_width     <= job_in_width;
            fu_weight_width <= job_weight_width;
            fu_s_in         <= job_s_in;
            fu_s_weight     <= job_s_weight;
            state           <= LOAD;
          end
        end
        LOAD: begin
          acc <= '0;
          cnt <= '0;
          if (!width_ok(fu_in_width) || !width_ok(fu_weight_width)) begin
            res_err   <= 1'b1;
            res_data  <= '0;
            res_valid <= 1'b1;
            state     <= DONE;
          end else if (len == '0) begin
            res_err   <= 1'b0;
            res_data  <= '0;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            din_ready <= 1'b1;
            state     <= STREAM;
          end
        end
        STREAM: begin
          if (din_valid && din_ready) begin
            fu_in     <= din_in;
            fu_weight <= din_weight;
            fu_valid  <= 1'b1;
            cnt       <= cnt + 1'b1;
            if (cnt + 1'b1 == len) begin
              din_ready <= 1'b0;
              state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // The final psum may land this very cycle, so publish acc_next.
          if (trk_empty) begin
            res_data  <= acc_next;
            res_err   <= 1'b0;
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            job_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fusion_seq_ctrl.sv
// Directed bench: two sequencers (FU_LAT 1 and 3) share stimulus, each with its own fusion_unit stand-in.
module tb_fusion_seq_ctrl;

  typedef struct packed {
    logic [7:0]  len;
    logic [2:0]  iw;
    logic [2:0]  ww;
    logic        si;
    logic        sw;
    logic [19:0] a;
    logic [19:0] b;
    logic [15:0] exp_data;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       job_valid = 1'b0;
  logic [7:0] job_len = '0;
  logic [2:0] job_in_width = '0;
  logic [2:0] job_weight_width = '0;
  logic       job_s_in = 1'b0;
  logic       job_s_weight = 1'b0;
  logic       din_valid = 1'b0;
  logic [3:0] din_in = '0;
  logic [3:0] din_weight = '0;
  logic       res_ready = 1'b1;

  logic [1:0]       job_ready, din_ready, fu_valid, fu_s_in, fu_s_weight, res_valid, res_err;
  logic [1:0][3:0]  fu_in, fu_weight;
  logic [1:0][2:0]  fu_in_width, fu_weight_width;
  logic [1:0][7:0]  fu_psum;
  logic [1:0][15:0] res_data;

  function automatic logic [7:0] fu_prod(input logic [3:0] x, input logic [3:0] y,
                                         input logic sx, input logic sy);
    logic [7:0] ex, ey;
    ex = sx ? {{4{x[3]}}, x} : {4'd0, x};
    ey = sy ? {{4{y[3]}}, y} : {4'd0, y};
    return 8'(ex * ey);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [7:0] pipe [LAT];

    fusion_seq_ctrl #(.LEN_W(8), .ACC_W(16), .FU_LAT(LAT)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .job_valid        (job_valid),
      .job_ready        (job_ready[g]),
      .job_len          (job_len),
      .job_in_width     (job_in_width),
      .job_weight_width (job_weight_width),
      .job_s_in         (job_s_in),
      .job_s_weight     (job_s_weight),
      .din_valid        (din_valid),
      .din_ready        (din_ready[g]),
      .din_in           (din_in),
      .din_weight       (din_weight),
      .fu_in            (fu_in[g]),
      .fu_weight        (fu_weight[g]),
      .fu_in_width      (fu_in_width[g]),
      .fu_weight_width  (fu_weight_width[g]),
      .fu_s_in          (fu_s_in[g]),
      .fu_s_weight      (fu_s_weight[g]),
      .fu_valid         (fu_valid[g]),
      .fu_psum          (fu_psum[g]),
      .res_valid        (res_valid[g]),
      .res_ready        (res_ready),
      .res_data         (res_data[g]),
      .res_err          (res_err[g])
    );

    // 4b x 4b multiplier with LAT cycles of latency.
    always @(posedge clk) begin
      pipe[0] <= fu_prod(fu_in[g], fu_weight[g], fu_s_in[g], fu_s_weight[g]);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign fu_psum[g] = pipe[LAT-1];
  end

  int fv_cnt [2];
  int dr_cnt [2];
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (fu_valid[g])  fv_cnt[g]++;
      if (din_ready[g]) dr_cnt[g]++;
    end
  end

  int total = 0;
  int bad = 0;
  logic       cfg_live = 1'b0;
  logic [7:0] cur_cfg = '0;
  int         cfg_bad [2];
  vec_t       vt [9];

  function automatic vec_t mk(input logic [7:0] len, input logic [2:0] iw, input logic [2:0] ww,
                              input logic si, input logic sw, input logic [19:0] a,
                              input logic [19:0] b, input logic [15:0] d, input logic e);
    vec_t v;
    v.len = len; v.iw = iw; v.ww = ww; v.si = si; v.sw = sw;
    v.a = a; v.b = b; v.exp_data = d; v.exp_err = e;
    return v;
  endfunction

  function automatic logic any_out(input int g);
    return job_ready[g] | din_ready[g] | (|fu_in[g]) | (|fu_weight[g]) | (|fu_in_width[g]) |
           (|fu_weight_width[g]) | fu_s_in[g] | fu_s_weight[g] | fu_valid[g] | res_valid[g] |
           (|res_data[g]) | res_err[g];
  endfunction

  task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, g, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (cfg_live)
      for (int g = 0; g < 2; g++)
        if ({fu_in_width[g], fu_weight_width[g], fu_s_in[g], fu_s_weight[g]} !== cur_cfg)
          cfg_bad[g]++;
  endtask

  task automatic start_job(input vec_t v);
    int n;
    job_len = v.len; job_in_width = v.iw; job_weight_width = v.ww;
    job_s_in = v.si; job_s_weight = v.sw; job_valid = 1'b1;
    n = 0;
    while (!(job_ready[0] && job_ready[1]) && n < 50) begin tick(); n++; end
    if (n >= 50) check("job_accept_timeout", 0, 1, 0);
    cur_cfg = {v.iw, v.ww, v.si, v.sw};
    cfg_live = 1'b1;
    cfg_bad[0] = 0; cfg_bad[1] = 0;
    tick();
    job_valid = 1'b0;
  endtask

  task automatic send_pairs(input vec_t v, input int npairs, input bit gappy);
    int k;
    for (int i = 0; i < npairs; i++) begin
      if (gappy) begin din_valid = 1'b0; tick(); end
      din_in = v.a[i*4 +: 4]; din_weight = v.b[i*4 +: 4]; din_valid = 1'b1;
      k = 0;
      while (!(din_ready[0] && din_ready[1]) && k < 20) begin tick(); k++; end
      if (k >= 20) begin check("din_ready_timeout", 0, 1, 0); din_valid = 1'b0; return; end
      tick();
    end
    din_valid = 1'b0;
  endtask

  task automatic run_job(input vec_t v, input bit gappy, input bit hold);
    int fv0 [2], dr0 [2];
    logic [1:0] got;
    logic [1:0][15:0] cd;
    logic [1:0] ce;
    int k, sbad, jbad;
    for (int g = 0; g < 2; g++) begin fv0[g] = fv_cnt[g]; dr0[g] = dr_cnt[g]; end
    res_ready = !hold;
    start_job(v);
    if (!v.exp_err && v.len != 0) send_pairs(v, int'(v.len), gappy);
    if (hold) begin
      k = 0;
      while (!(res_valid[0] && res_valid[1]) && k < 100) begin tick(); k++; end
      if (k >= 100) check("hold_wait_timeout", 0, 1, 0);
      job_valid = 1'b1;
      sbad = 0; jbad = 0;
      for (int c = 0; c < 10; c++) begin
        tick();
        for (int g = 0; g < 2; g++) begin
          if (!res_valid[g] || res_data[g] !== v.exp_data) sbad++;
          if (job_ready[g]) jbad++;
        end
      end
      check("hold_result_stable", 0, sbad, 0);
      check("hold_job_ready_low", 0, jbad, 0);
      job_valid = 1'b0;
      res_ready = 1'b1;
    end
    got = '0; cd = '0; ce = '0; k = 0;
    while (got != 2'b11 && k < 100) begin
      for (int g = 0; g < 2; g++)
        if (!got[g] && res_valid[g] && res_ready) begin
          got[g] = 1'b1; cd[g] = res_data[g]; ce[g] = res_err[g];
        end
      if (got != 2'b11) begin tick(); k++; end
    end
    tick(); tick();
    cfg_live = 1'b0;
    for (int g = 0; g < 2; g++) begin
      check("result_seen", g, got[g], 1);
      check("res_data", g, cd[g], v.exp_data);
      check("res_err", g, ce[g], v.exp_err);
      check("fu_valid_cycles", g, fv_cnt[g] - fv0[g], v.exp_err ? 0 : int'(v.len));
      check("config_stable", g, cfg_bad[g], 0);
      if (v.exp_err || v.len == 0) check("no_din_ready", g, dr_cnt[g] - dr0[g], 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Pairs packed right to left: element 0 in the low nibble.
    vt[0] = mk(8'd3, 3'd4, 3'd4, 1'b0, 1'b0, 20'h00F23, 20'h00F75, 16'd254,  1'b0);
    vt[1] = mk(8'd1, 3'd4, 3'd4, 1'b1, 1'b1, 20'h00008, 20'h00003, 16'hFFE8, 1'b0);
    vt[2] = mk(8'd2, 3'd4, 3'd4, 1'b0, 1'b1, 20'h00012, 20'h0001F, 16'hFFFF, 1'b0);
    vt[3] = mk(8'd4, 3'd4, 3'd4, 1'b1, 1'b1, 20'h09F87, 20'h02187, 16'h0062, 1'b0);
    vt[4] = mk(8'd0, 3'd4, 3'd4, 1'b0, 1'b0, 20'h00000, 20'h00000, 16'h0000, 1'b0);
    vt[5] = mk(8'd3, 3'd3, 3'd4, 1'b0, 1'b0, 20'h00123, 20'h00123, 16'h0000, 1'b1);
    vt[6] = mk(8'd0, 3'd2, 3'd1, 1'b0, 1'b0, 20'h00000, 20'h00000, 16'h0000, 1'b0);
    vt[7] = mk(8'd2, 3'd4, 3'd0, 1'b0, 1'b0, 20'h00011, 20'h00011, 16'h0000, 1'b1);
    vt[8] = mk(8'd5, 3'd4, 3'd4, 1'b0, 1'b0, 20'h54321, 20'hFFFFF, 16'h00E1, 1'b0);

    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) check("reset_outputs_zero", g, any_out(g), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_job(vt[i], 1'b0, 1'b0);

    run_job(vt[0], 1'b1, 1'b0);
    run_job(vt[1], 1'b0, 1'b1);

    // Abort a five-pair job after two pairs; the in-flight psum must be discarded.
    res_ready = 1'b1;
    start_job(vt[8]);
    send_pairs(vt[8], 2, 1'b0);
    cfg_live = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) check("async_reset_outputs", g, any_out(g), 0);
    @(negedge clk); @(negedge clk);
    for (int g = 0; g < 2; g++) check("reset_held_outputs", g, any_out(g), 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_job(vt[0], 1'b0, 1'b0);
    run_job(vt[3], 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
